// File: rtl/switch_conditioner_if.sv
// switch_conditioner_if: raw switch inputs and conditioned outputs between the board and picoMips.
interface switch_conditioner_if #(parameter int DATA_WIDTH = 8);
    logic [9:0]            SWRaw;
    logic                  SyncNReset;
    logic [DATA_WIDTH-1:0] SWData;
    logic [DATA_WIDTH-1:0] SWLive;
    logic                  Handshake;
    logic                  HandshakeRise;
    logic                  HandshakeFall;
    modport master (output SWRaw, input SyncNReset, SWData, SWLive, Handshake, HandshakeRise, HandshakeFall);
    modport slave  (input SWRaw, output SyncNReset, SWData, SWLive, Handshake, HandshakeRise, HandshakeFall);
endinterface

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronises the board switches and debounces the handshake switch,
// capturing the data byte on each accepted handshake rise.
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DATA_WIDTH      = 8
) (
    input logic                Clock,
    input logic                Reset,
    switch_conditioner_if.slave sw
);
    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
    state_t                state;
    logic [7:0]            cnt;
    logic [9:0]            s1, s2;
    logic [DATA_WIDTH-1:0] data;
    logic                  hs, rise, fall;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1    <= '0;
            s2    <= '0;
            state <= LOW;
            cnt   <= '0;
            data  <= '0;
            hs    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= sw.SWRaw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                LOW:
                    if (s2[8]) begin
                        state <= WAIT_HIGH;
                        cnt   <= 8'd1;
                    end else cnt <= '0;
                WAIT_HIGH:
                    if (!s2[8]) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= HIGH;
                        cnt   <= '0;
                        hs    <= 1'b1;
                        rise  <= 1'b1;
                        data  <= s2[DATA_WIDTH-1:0];
                    end else cnt <= cnt + 8'd1;
                HIGH:
                    if (!s2[8]) begin
                        state <= WAIT_LOW;
                        cnt   <= 8'd1;
                    end else cnt <= '0;
                WAIT_LOW:
                    if (s2[8]) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                        hs    <= 1'b0;
                        fall  <= 1'b1;
                    end else cnt <= cnt + 8'd1;
                default: state <= LOW;
            endcase
        end
    end
    assign sw.SyncNReset    = s2[9];
    assign sw.SWLive        = s2[DATA_WIDTH-1:0];
    assign sw.SWData        = data;
    assign sw.Handshake     = hs;
    assign sw.HandshakeRise = rise;
    assign sw.HandshakeFall = fall;
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: per-edge vector table for switch_conditioner with DEBOUNCE_CYCLES=4.
module tb_switch_conditioner;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    switch_conditioner_if #(.DATA_WIDTH(8)) sw ();
    switch_conditioner #(.DEBOUNCE_CYCLES(4), .DATA_WIDTH(8)) dut (.Clock(Clock), .Reset(Reset), .sw(sw));
    always #5 Clock = ~Clock;
    typedef struct {
        logic        rst;
        logic [9:0]  raw;
        logic [19:0] exp;
    } vec_t;
    vec_t tbl[$];
    task automatic add(input int n, input logic r, input logic [9:0] raw, input logic s,
                       input logic [7:0] d, input logic [7:0] l, input logic h, input logic ri, input logic f);
        vec_t v;
        v.rst = r;
        v.raw = raw;
        v.exp = {s, d, l, h, ri, f};
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask
    function automatic logic [19:0] outs();
        return {sw.SyncNReset, sw.SWData, sw.SWLive, sw.Handshake, sw.HandshakeRise, sw.HandshakeFall};
    endfunction
    task automatic check(input string name, input logic [19:0] want);
        logic [19:0] got;
        got = outs();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got {nrst,data,live,hs,rise,fall}=%h want %h", name, got, want);
        end
    endtask
    initial begin
        // release from reset
        add(1, 0, 10'h3FF, 0, 8'h00, 8'h00, 0, 0, 0);
        add(4, 0, 10'h3FF, 1, 8'h00, 8'hFF, 0, 0, 0);
        add(1, 0, 10'h3FF, 1, 8'hFF, 8'hFF, 1, 1, 0);
        add(1, 0, 10'h3FF, 1, 8'hFF, 8'hFF, 1, 0, 0);
        // release handshake; data changes ignored by SWData
        add(1, 0, 10'h2A5, 1, 8'hFF, 8'hFF, 1, 0, 0);
        add(4, 0, 10'h2A5, 1, 8'hFF, 8'hA5, 1, 0, 0);
        add(1, 0, 10'h2A5, 1, 8'hFF, 8'hA5, 0, 0, 1);
        add(1, 0, 10'h2A5, 1, 8'hFF, 8'hA5, 0, 0, 0);
        // clean press with A5
        add(5, 0, 10'h3A5, 1, 8'hFF, 8'hA5, 0, 0, 0);
        add(1, 0, 10'h3A5, 1, 8'hA5, 8'hA5, 1, 1, 0);
        add(1, 0, 10'h3A5, 1, 8'hA5, 8'hA5, 1, 0, 0);
        // data change while high
        add(1, 0, 10'h33C, 1, 8'hA5, 8'hA5, 1, 0, 0);
        add(2, 0, 10'h33C, 1, 8'hA5, 8'h3C, 1, 0, 0);
        // release again
        add(5, 0, 10'h23C, 1, 8'hA5, 8'h3C, 1, 0, 0);
        add(1, 0, 10'h23C, 1, 8'hA5, 8'h3C, 0, 0, 1);
        add(1, 0, 10'h23C, 1, 8'hA5, 8'h3C, 0, 0, 0);
        // bounce: high 2, low 1, then high held
        add(2, 0, 10'h33C, 1, 8'hA5, 8'h3C, 0, 0, 0);
        add(1, 0, 10'h23C, 1, 8'hA5, 8'h3C, 0, 0, 0);
        add(5, 0, 10'h33C, 1, 8'hA5, 8'h3C, 0, 0, 0);
        add(1, 0, 10'h33C, 1, 8'h3C, 8'h3C, 1, 1, 0);
        add(1, 0, 10'h33C, 1, 8'h3C, 8'h3C, 1, 0, 0);
        // back to low
        add(5, 0, 10'h23C, 1, 8'h3C, 8'h3C, 1, 0, 0);
        add(1, 0, 10'h23C, 1, 8'h3C, 8'h3C, 0, 0, 1);
        add(1, 0, 10'h23C, 1, 8'h3C, 8'h3C, 0, 0, 0);
        // press interrupted by reset at edge 4, then full requalification
        add(1, 0, 10'h35A, 1, 8'h3C, 8'h3C, 0, 0, 0);
        add(2, 0, 10'h35A, 1, 8'h3C, 8'h5A, 0, 0, 0);
        add(1, 1, 10'h35A, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 0, 10'h35A, 0, 8'h00, 8'h00, 0, 0, 0);
        add(4, 0, 10'h35A, 1, 8'h00, 8'h5A, 0, 0, 0);
        add(1, 0, 10'h35A, 1, 8'h5A, 8'h5A, 1, 1, 0);
        add(1, 0, 10'h35A, 1, 8'h5A, 8'h5A, 1, 0, 0);
        sw.SWRaw = '0;
        Reset = 1'b1;
        #1 check("reset_initial", 20'h0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        sw.SWRaw = 10'h3FF;
        repeat (6) @(posedge Clock);
        #1 check("pre_reset_accept", {1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0});
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1 check("async_reset_midcycle", 20'h0);
        foreach (tbl[i]) begin
            @(negedge Clock);
            Reset = tbl[i].rst;
            sw.SWRaw = tbl[i].raw;
            @(posedge Clock);
            #1 check($sformatf("row%0d", i), tbl[i].exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
